mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if : request/response bus between an initiator and mem_responder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_responder_if;
   logic        req;
   logic        wr;
   logic [31:0] addr;
   logic [1:0]  size;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
   logic        err;

   modport master (
      output req, wr, addr, size, wdata,
      input  rdata, ready, busy, err
   );

   modport slave (
      input  req, wr, addr, size, wdata,
      output rdata, ready, busy, err
   );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder : fixed-latency single-outstanding word memory responder
// Option macro: MEM_RESPONDER_MISALIGN_TRAP_EN (misaligned accesses flag err)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic            clk,
   input  logic            reset,
   mem_responder_if.slave  bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  state, state_nx;
   logic [3:0]              cnt, cnt_nx;
   logic                    wr_q, wr_nx;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_nx;
   logic [1:0]              lo_q, lo_nx;
   logic [1:0]              size_q, size_nx;
   logic [31:0]             wdata_q, wdata_nx;
   logic [31:0]             rdata_q, rdata_nx;
   logic                    ready_q, ready_nx;
   logic                    busy_q, busy_nx;
   logic                    err_q, err_nx;

   logic [31:0]             mem [DEPTH];
   logic                    bad_acc;
   logic [3:0]              lane_en;
   logic [31:0]             lane_data;
   logic                    commit;
   logic                    unused_addr;

   assign unused_addr = ^bus.addr;

   // Access decode on the latched request; sub-word data is replicated so any lane can pick it up.
   always_comb begin
      bad_acc = (size_q == 2'b11);
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
      if ((size_q == 2'b01) && lo_q[0])
         bad_acc = 1'b1;
      if ((size_q == 2'b10) && (lo_q != 2'b00))
         bad_acc = 1'b1;
`endif
      case (size_q)
         2'b00: begin
            lane_en   = 4'b0001 << lo_q;
            lane_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            lane_en   = lo_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_q[15:0]}};
         end
         default: begin
            lane_en   = 4'b1111;
            lane_data = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      wr_nx    = wr_q;
      idx_nx   = idx_q;
      lo_nx    = lo_q;
      size_nx  = size_q;
      wdata_nx = wdata_q;
      rdata_nx = 32'h0;
      ready_nx = 1'b0;
      err_nx   = 1'b0;
      busy_nx  = busy_q;
      commit   = 1'b0;
      case (state)
         S_IDLE: begin
            busy_nx = 1'b0;
            if (bus.req) begin
               wr_nx    = bus.wr;
               idx_nx   = bus.addr[DEPTH_LOG2+1:2];
               lo_nx    = bus.addr[1:0];
               size_nx  = bus.size;
               wdata_nx = bus.wdata;
               cnt_nx   = 4'(LATENCY - 1);
               busy_nx  = 1'b1;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               state_nx = S_RESP;
               ready_nx = 1'b1;
               err_nx   = bad_acc;
               rdata_nx = (!wr_q && !bad_acc) ? mem[idx_q] : 32'h0;
               commit   = wr_q && !bad_acc;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         S_RESP: begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
         end
         default: begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         lo_q    <= 2'b00;
         size_q  <= 2'b00;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         wr_q    <= wr_nx;
         idx_q   <= idx_nx;
         lo_q    <= lo_nx;
         size_q  <= size_nx;
         wdata_q <= wdata_nx;
         rdata_q <= rdata_nx;
         ready_q <= ready_nx;
         busy_q  <= busy_nx;
         err_q   <= err_nx;
      end
   end

   // Storage is deliberately not reset; a reset edge only suppresses the pending commit.
   always_ff @(posedge clk) begin
      if (reset && commit) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_en[b])
               mem[idx_q][8*b +: 8] <= lane_data[8*b +: 8];
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder : randomized bench against a byte-addressed reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

   localparam int DL2 = 8;
   localparam int LAT = 2;
   localparam int NB  = 4 << DL2;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   logic [7:0]  mb [NB];
   logic [31:0] last_rd;
   logic        last_err;

   mem_responder_if bus();

   mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [31:0] a);
      int wb;
      logic [31:0] r;
      wb = int'(a[DL2+1:0]) & ~3;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = mb[wb + k];
      return r;
   endfunction

   // One complete transaction: model update, drive, latency and response checks.
   task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          n, nb, ba;
      exp_err = (s == 2'b11);
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
      if ((s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)) exp_err = 1'b1;
`endif
      exp_rd = 32'h0;
      if (!exp_err) begin
         nb = 1 << s;
         ba = int'(a[DL2+1:0]) & ~(nb - 1);
         if (w) begin
            for (int k = 0; k < nb; k++) mb[ba + k] = d[8*k +: 8];
         end else begin
            exp_rd = model_word(a);
         end
      end
      @(negedge clk);
      bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.size = s; bus.wdata = d;
      @(posedge clk); #1;
      bus.req = 1'b0;
      check("busy_on_accept", 32'(bus.busy), 32'd1);
      check("ready_at_accept", 32'(bus.ready), 32'd0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.ready && n < 16);
      check("latency", n, LAT);
      check("rdata", bus.rdata, exp_rd);
      check("err", 32'(bus.err), 32'(exp_err));
      last_rd  = bus.rdata;
      last_err = bus.err;
      @(posedge clk); #1;
      check("ready_pulse_end", 32'(bus.ready), 32'd0);
      check("busy_end", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int          rdy_at[$];
      int          lows;
      logic        seen;
      logic [31:0] old, w32;

      bus.req = 1'b0; bus.wr = 1'b0; bus.addr = 32'h0; bus.size = 2'b00; bus.wdata = 32'h0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      @(negedge clk) reset = 1'b1;

      for (int i = 0; i < (1 << DL2); i++) xact(1'b1, 32'(i * 4), 2'b10, $urandom());

      xact(1'b1, 32'h10, 2'b10, 32'hDEADBEEF);
      xact(1'b0, 32'h10, 2'b10, 32'h0);
      check("d33_load", last_rd, 32'hDEADBEEF);

      xact(1'b1, 32'h20, 2'b10, 32'h11223344);
      xact(1'b1, 32'h22, 2'b00, 32'h000000AB);
      xact(1'b0, 32'h20, 2'b10, 32'h0);
      check("d34_byte", last_rd, 32'h11AB3344);
      xact(1'b1, 32'h20, 2'b01, 32'h0000CAFE);
      xact(1'b0, 32'h20, 2'b10, 32'h0);
      check("d34_half", last_rd, 32'h11ABCAFE);

      xact(1'b1, 32'h400, 2'b10, 32'h5A5A5A5A);
      xact(1'b0, 32'h0, 2'b10, 32'h0);
      check("d35_wrap", last_rd, 32'h5A5A5A5A);

      // Abort a store with reset one edge after acceptance.
      old = model_word(32'h30);
      @(negedge clk);
      bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'h30; bus.size = 2'b10; bus.wdata = ~old;
      @(posedge clk); #1;
      bus.req = 1'b0;
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_ready", 32'(bus.ready), 32'd0);
      @(negedge clk) reset = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.ready) seen = 1'b1;
      end
      check("abort_no_ready", 32'(seen), 32'd0);
      xact(1'b0, 32'h30, 2'b10, 32'h0);
      check("abort_prior", last_rd, old);

      // Reset and request at the same edge: request dropped.
      @(negedge clk);
      reset = 1'b0; bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'h30; bus.size = 2'b10;
      @(posedge clk); #1;
      check("rst_req_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      reset = 1'b1; bus.req = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.ready || bus.busy) seen = 1'b1;
      end
      check("rst_req_dropped", 32'(seen), 32'd0);

      // Misaligned and reserved-size accesses.
      xact(1'b0, 32'h32, 2'b10, 32'h0);
      xact(1'b0, 32'h33, 2'b01, 32'h0);
      xact(1'b1, 32'h31, 2'b10, 32'h12345678);
      xact(1'b0, 32'h30, 2'b10, 32'h0);
      xact(1'b0, 32'h30, 2'b11, 32'h0);
      check("size11_err", 32'(last_err), 32'd1);
      xact(1'b1, 32'h30, 2'b11, 32'hFFFFFFFF);
      xact(1'b0, 32'h30, 2'b10, 32'h0);

      // req held high: one ready per request, one idle cycle between transactions.
      w32 = model_word(32'h10);
      @(negedge clk);
      bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'h10; bus.size = 2'b10;
      lows = 0;
      for (int c = 0; c < 4 * (LAT + 2); c++) begin
         @(posedge clk); #1;
         if (bus.ready) begin
            check("b2b_rdata", bus.rdata, w32);
            if (rdy_at.size() > 0) begin
               check("b2b_spacing", c - rdy_at[$], LAT + 2);
               check("b2b_busy_low", lows, 1);
            end
            rdy_at.push_back(c);
            lows = 0;
         end else if (!bus.busy && rdy_at.size() > 0) begin
            lows++;
         end
      end
      check("b2b_count", rdy_at.size(), 4);
      @(negedge clk) bus.req = 1'b0;
      repeat (LAT + 3) @(posedge clk);

      for (int i = 0; i < 300; i++)
         xact(1'($urandom_range(0, 1)), $urandom(), 2'($urandom_range(0, 3)), $urandom());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
